// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the flappy-style game controller.
package game_pkg;

    // Playfield geometry and the fixed column the bird occupies.
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BIRD_X   = 4;

    // Positions loaded at reset and at the start of every round.
    localparam logic [6:0] RESET_BOX_Y  = 7'd60;
    localparam logic [7:0] RESET_PIPE_X = 8'd159;
    localparam logic [6:0] RESET_PIPE_Y = 7'd40;
    localparam logic [7:0] LFSR_SEED    = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN_WAIT = 3'd1,
        S_PULSE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_UPDATE   = 3'd4,
        S_OVER     = 3'd5
    } game_state_t;

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR; zero is unreachable from a nonzero seed.
    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/game_tick_divider.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
module game_tick_divider #(
    parameter int TICK_DIV = 833333
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick_hit
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    // Count 0..TICK_DIV-1 and wrap; the strobe marks the last count before the wrap.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick_hit = (r_count == LAST);

endmodule

// File: rtl/game_controller.sv
// Game state machine: paces the painter with a pulse/ack handshake and moves bird and pipe once per tick.
module game_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV = 833333,
    parameter int GAP_H    = 20,
    parameter int FLAP_V   = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       flap,
    input  logic       game_tick_after_draw,
    output logic       game_pulse,
    output logic [6:0] box_y,
    output logic [7:0] pipe_one_x,
    output logic [6:0] pipe_one_y,
    output logic       game_over,
    output logic [7:0] score
);

    localparam logic signed [3:0] FLAP_VEL = 4'(-FLAP_V);
    localparam logic signed [3:0] VEL_MAX  = 4'sd7;
    localparam logic signed [7:0] Y_WALL   = 8'(SCREEN_H - 1);
    localparam logic [6:0]        Y_MAX    = 7'(SCREEN_H - 2);
    localparam logic [7:0]        X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [7:0]        X_NEAR   = 8'(BIRD_X - 1);
    localparam logic [7:0]        X_FAR    = 8'(BIRD_X + 1);
    localparam logic [8:0]        GAP_SPAN = 9'(GAP_H);

    game_state_t       r_state;
    logic              r_game_pulse;
    logic              r_game_over;
    logic [6:0]        r_box_y;
    logic signed [3:0] r_vel;
    logic [7:0]        r_pipe_x;
    logic [6:0]        r_pipe_y;
    logic [7:0]        r_score;
    logic              r_flap_latch;
    logic              r_flap_prev;
    logic              r_ack_sample;
    logic [7:0]        r_lfsr;

    logic              w_tick_hit;
    logic              w_flap_edge;
    logic              w_ack_seen;
    logic signed [3:0] w_vel_next;
    logic signed [7:0] w_y_sum;
    logic [6:0]        w_box_y_next;
    logic              w_hit_wall;
    logic [7:0]        w_pipe_x_next;
    logic [6:0]        w_pipe_y_next;
    logic [7:0]        w_lfsr_mod;
    logic [8:0]        w_bird_top;
    logic [8:0]        w_bird_bot;
    logic [8:0]        w_gap_top;
    logic [8:0]        w_gap_end;
    logic              w_hit_pipe;
    logic [7:0]        w_score_next;

    game_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick_hit (w_tick_hit)
    );

    assign w_flap_edge = flap & ~r_flap_prev;
    assign w_ack_seen  = (game_tick_after_draw != r_ack_sample);

    // Remember the previous key level and, outside WAIT_ACK, track the ack toggle so PULSE captures it.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_flap_prev  <= 1'b0;
            r_ack_sample <= 1'b0;
        end else begin
            r_flap_prev <= flap;
            if (r_state != S_WAIT_ACK) begin
                r_ack_sample <= game_tick_after_draw;
            end
        end
    end

    // Free-running pseudo-random source for new pipe gap positions.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsrNext(r_lfsr);
        end
    end

    // Next-tick physics: velocity, vertical motion with wall clamp, pipe scroll, collision and score.
    always_comb begin
        w_vel_next    = r_vel;
        w_box_y_next  = r_box_y;
        w_hit_wall    = 1'b0;
        w_pipe_x_next = r_pipe_x - 8'd1;
        w_pipe_y_next = r_pipe_y;
        w_lfsr_mod    = (r_lfsr % 8'd80) + 8'd10;

        if (r_flap_latch) begin
            w_vel_next = FLAP_VEL;
        end else if (r_vel >= VEL_MAX) begin
            w_vel_next = VEL_MAX;
        end else begin
            w_vel_next = r_vel + 4'sd1;
        end

        w_y_sum = $signed({1'b0, r_box_y}) + $signed({{4{w_vel_next[3]}}, w_vel_next});
        if (w_y_sum <= 8'sd0) begin
            w_box_y_next = 7'd1;
            w_hit_wall   = 1'b1;
        end else if (w_y_sum >= Y_WALL) begin
            w_box_y_next = Y_MAX;
            w_hit_wall   = 1'b1;
        end else begin
            w_box_y_next = w_y_sum[6:0];
        end

        if (r_pipe_x == 8'd0) begin
            w_pipe_x_next = X_LAST;
            w_pipe_y_next = w_lfsr_mod[6:0];
        end

        w_bird_top = {2'b00, w_box_y_next} - 9'd1;
        w_bird_bot = {2'b00, w_box_y_next} + 9'd1;
        w_gap_top  = {2'b00, w_pipe_y_next};
        w_gap_end  = {2'b00, w_pipe_y_next} + GAP_SPAN;
        w_hit_pipe = (w_pipe_x_next >= X_NEAR) && (w_pipe_x_next <= X_FAR) &&
                     ((w_bird_top < w_gap_top) || (w_bird_bot >= w_gap_end));

        w_score_next = r_score;
        if ((r_pipe_x == X_NEAR) && (r_score != 8'hFF)) begin
            w_score_next = r_score + 8'd1;
        end
    end

    // Round sequencing, painter handshake and registered game state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_game_pulse <= 1'b0;
            r_game_over  <= 1'b0;
            r_box_y      <= RESET_BOX_Y;
            r_vel        <= 4'sd0;
            r_pipe_x     <= RESET_PIPE_X;
            r_pipe_y     <= RESET_PIPE_Y;
            r_score      <= 8'd0;
            r_flap_latch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_game_pulse <= 1'b0;
                    r_game_over  <= 1'b0;
                    r_flap_latch <= 1'b0;
                    if (start) begin
                        r_state  <= S_RUN_WAIT;
                        r_box_y  <= RESET_BOX_Y;
                        r_vel    <= 4'sd0;
                        r_pipe_x <= RESET_PIPE_X;
                        r_pipe_y <= RESET_PIPE_Y;
                        r_score  <= 8'd0;
                    end
                end
                S_RUN_WAIT: begin
                    r_flap_latch <= r_flap_latch | w_flap_edge;
                    if (w_tick_hit) begin
                        r_state      <= S_PULSE;
                        r_game_pulse <= 1'b1;
                    end
                end
                S_PULSE: begin
                    r_flap_latch <= r_flap_latch | w_flap_edge;
                    r_game_pulse <= 1'b0;
                    r_state      <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    r_flap_latch <= r_flap_latch | w_flap_edge;
                    if (w_ack_seen) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_flap_latch <= w_flap_edge;
                    r_vel        <= w_vel_next;
                    r_box_y      <= w_box_y_next;
                    r_pipe_x     <= w_pipe_x_next;
                    r_pipe_y     <= w_pipe_y_next;
                    r_score      <= w_score_next;
                    if (w_hit_wall || w_hit_pipe) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= S_RUN_WAIT;
                    end
                end
                S_OVER: begin
                    r_flap_latch <= 1'b0;
                    r_game_pulse <= 1'b0;
                    if (!start) begin
                        r_state     <= S_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_game_pulse <= 1'b0;
                    r_game_over  <= 1'b0;
                end
            endcase
        end
    end

    assign game_pulse = r_game_pulse;
    assign game_over  = r_game_over;
    assign box_y      = r_box_y;
    assign pipe_one_x = r_pipe_x;
    assign pipe_one_y = r_pipe_y;
    assign score      = r_score;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench: acts as the painter, keeps a reference model, and scoreboards every update.
module tb_game_controller;

    localparam int TICK_DIV = 10;
    localparam int GAP_H    = 20;
    localparam int FLAP_V   = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       flap = 1'b0;
    logic       game_tick_after_draw = 1'b0;
    logic       game_pulse;
    logic [6:0] box_y;
    logic [7:0] pipe_one_x;
    logic [6:0] pipe_one_y;
    logic       game_over;
    logic [7:0] score;

    typedef struct {
        int y;
        int x;
        int py;
        int score;
        bit over;
        bit pyKnown;
    } expect_t;

    expect_t sbQueue[$];

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;
    int lastPulseCycle = 0;
    int pulsePeriod = 0;
    bit tbAbort = 1'b0;

    int mY, mVel, mX, mPy, mScore;
    bit mOver, mPend, mPyKnown, mWrapped;

    game_controller #(
        .TICK_DIV (TICK_DIV),
        .GAP_H    (GAP_H),
        .FLAP_V   (FLAP_V)
    ) dut (
        .CLOCK_50             (CLOCK_50),
        .resetn               (resetn),
        .start                (start),
        .flap                 (flap),
        .game_tick_after_draw (game_tick_after_draw),
        .game_pulse           (game_pulse),
        .box_y                (box_y),
        .pipe_one_x           (pipe_one_x),
        .pipe_one_y           (pipe_one_y),
        .game_over            (game_over),
        .score                (score)
    );

    // 50 MHz-style free-running clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    // Cycle counter used to measure the pulse period.
    always @(posedge CLOCK_50) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mY = 60; mVel = 0; mX = 159; mPy = 40; mScore = 0;
        mOver = 0; mPend = 0; mPyKnown = 1; mWrapped = 0;
    endtask

    task automatic modelStep();
        bit wall;
        bit pipeHit;
        wall = 0;
        if (mPend) begin
            mVel = -FLAP_V;
            mPend = 0;
        end else if (mVel < 7) begin
            mVel = mVel + 1;
        end
        mY = mY + mVel;
        if (mY <= 0) begin
            mY = 1;
            wall = 1;
        end else if (mY >= 119) begin
            mY = 118;
            wall = 1;
        end
        if (mX == 3 && mScore < 255) mScore = mScore + 1;
        if (mX == 0) begin
            mX = 159;
            mPyKnown = 0;
            mWrapped = 1;
        end else begin
            mX = mX - 1;
        end
        pipeHit = (mX >= 3) && (mX <= 5) && mPyKnown && ((mY - 1 < mPy) || (mY + 1 >= mPy + GAP_H));
        mOver = wall || pipeHit;
    endtask

    // One painter pass: wait for the pulse, optionally flap, ack after ackDelay cycles, then score the update.
    task automatic applyStimulus(input bit pressFlap, input bit holdFlap, input int ackDelay);
        int n;
        int extra;
        bit got;
        expect_t e;
        expect_t a;
        n = 0;
        got = 0;
        extra = 0;
        while (n < 40 && !got) begin
            @(negedge CLOCK_50);
            if (game_pulse) got = 1;
            n++;
        end
        if (!got) begin
            checkOutput("pulse_seen", 0, 1);
            tbAbort = 1;
            return;
        end
        pulsePeriod = cycleCount - lastPulseCycle;
        lastPulseCycle = cycleCount;
        for (int i = 1; i <= ackDelay; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) begin
                checkOutput("pulse_width", int'(game_pulse), 0);
                if (pressFlap) begin
                    flap = 1'b1;
                    mPend = 1;
                    if (holdFlap) begin
                        fork
                            begin
                                repeat (50) @(negedge CLOCK_50);
                                flap = 1'b0;
                            end
                        join_none
                    end
                end
            end else begin
                if (i == 2 && pressFlap && !holdFlap) flap = 1'b0;
                if (game_pulse) extra++;
            end
        end
        if (ackDelay > 3) begin
            checkOutput("no_extra_pulse", extra, 0);
            checkOutput("frozen_box_y", int'(box_y), mY);
            checkOutput("frozen_pipe_x", int'(pipe_one_x), mX);
        end
        game_tick_after_draw = ~game_tick_after_draw;
        modelStep();
        e.y = mY; e.x = mX; e.py = mPy; e.score = mScore; e.over = mOver; e.pyKnown = mPyKnown;
        sbQueue.push_back(e);
        repeat (3) @(negedge CLOCK_50);
        a = sbQueue.pop_front();
        checkOutput("box_y", int'(box_y), a.y);
        checkOutput("pipe_one_x", int'(pipe_one_x), a.x);
        checkOutput("score", int'(score), a.score);
        checkOutput("game_over", int'(game_over), int'(a.over));
        if (a.pyKnown) checkOutput("pipe_one_y", int'(pipe_one_y), a.py);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pulse"}, int'(game_pulse), 0);
        checkOutput({tag, "_over"}, int'(game_over), 0);
        checkOutput({tag, "_box_y"}, int'(box_y), 60);
        checkOutput({tag, "_pipe_x"}, int'(pipe_one_x), 159);
        checkOutput({tag, "_pipe_y"}, int'(pipe_one_y), 40);
        checkOutput({tag, "_score"}, int'(score), 0);
    endtask

    task automatic restartRound();
        start = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("idle_game_over", int'(game_over), 0);
        start = 1'b1;
        @(negedge CLOCK_50);
        modelReset();
        checkOutput("reload_box_y", int'(box_y), mY);
        checkOutput("reload_pipe_x", int'(pipe_one_x), mX);
        checkOutput("reload_score", int'(score), mScore);
    endtask

    task automatic checkQuietOver(input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLOCK_50);
            flap = (i == 5) ? 1'b1 : 1'b0;
            if (game_pulse) pulses++;
        end
        flap = 1'b0;
        checkOutput("over_no_pulse", pulses, 0);
        checkOutput("over_held", int'(game_over), 1);
        checkOutput("over_frozen_y", int'(box_y), mY);
    endtask

    initial begin
        int n;
        int pulses;
        bit got;
        modelReset();

        #3 resetn = 1'b0;
        #2;
        checkResetValues("reset");
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);

        // Round A: free fall, one held flap, velocity cap, then bottom wall clamp.
        $display("[TB] round A: fall, held flap, wall collision");
        for (int t = 1; t <= 4 && !tbAbort; t++) begin
            applyStimulus(0, 0, 3);
            if (t >= 2) checkOutput("pulse_period", pulsePeriod, TICK_DIV);
        end
        if (!tbAbort) applyStimulus(1, 1, 3);
        n = 0;
        while (!mOver && !tbAbort && n < 40) begin
            applyStimulus(0, 0, 3);
            n++;
        end
        checkOutput("roundA_over", int'(game_over), 1);
        checkOutput("roundA_clamp", int'(box_y), 118);
        checkQuietOver(30);
        restartRound();

        // Round B: withheld ack, then reset in the middle of a handshake.
        $display("[TB] round B: withheld ack and mid-handshake reset");
        if (!tbAbort) applyStimulus(0, 0, 35);
        if (!tbAbort) applyStimulus(0, 0, 3);
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            @(negedge CLOCK_50);
            if (game_pulse) got = 1;
            n++;
        end
        checkOutput("resetB_pulse_seen", int'(got), 1);
        @(negedge CLOCK_50);
        start = 1'b0;
        resetn = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge CLOCK_50);
        resetn = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (game_pulse) pulses++;
        end
        checkOutput("idle_no_pulse", pulses, 0);
        checkOutput("idle_box_y", int'(box_y), 60);
        start = 1'b1;
        @(negedge CLOCK_50);
        modelReset();

        // Round C: hover above the gap so the pipe strikes the bird.
        $display("[TB] round C: pipe collision");
        n = 0;
        while (!mOver && !tbAbort && n < 200) begin
            applyStimulus(mY > 30, 0, 3);
            n++;
        end
        checkOutput("roundC_over", int'(game_over), 1);
        checkOutput("roundC_score", int'(score), 0);
        checkQuietOver(20);
        restartRound();

        // Round D: fly through the gap, score, and watch the pipe wrap.
        $display("[TB] round D: pass pipe and wrap");
        n = 0;
        while (!mWrapped && !mOver && !tbAbort && n < 200) begin
            applyStimulus(mY > 50, 0, 3);
            n++;
        end
        checkOutput("roundD_wrapped", int'(mWrapped), 1);
        checkOutput("roundD_score", int'(score), 1);
        checkOutput("roundD_alive", int'(game_over), 0);
        checkOutput("wrap_pipe_y_range", int'(pipe_one_y >= 7'd10 && pipe_one_y <= 7'd89), 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 833333, CLOCK_50 cycles per game tick (60 Hz).
REQ-002 Parameter GAP_H, default 20, pipe gap height in rows.
REQ-003 Parameter FLAP_V, default 4, upward speed loaded on flap, rows/tick.
REQ-004 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; high in IDLE or OVER starts a new round.
REQ-007 flap  in  1  raw level from key, active-high; rising edge detected internally.
REQ-008 game_tick_after_draw  in  1  toggle from painter; each change acknowledges one erase/draw pass.
REQ-009 game_pulse  out  1  one-cycle strobe requesting painter erase/redraw.
REQ-010 box_y  out  7  bird centre row, 1..118.
REQ-011 pipe_one_x  out  8  pipe column, 0..159.
REQ-012 pipe_one_y  out  7  top row of pipe gap.
REQ-013 game_over  out  1  high while in OVER.
REQ-014 score  out  8  pipes passed, saturating.

Function
REQ-015 Tick counter counts 0..TICK_DIV-1 continuously, wraps to 0; tick_hit asserted for one cycle on wrap.
REQ-016 States: IDLE, RUN_WAIT, PULSE, WAIT_ACK, UPDATE, OVER.
REQ-017 IDLE -> RUN_WAIT when start=1; OVER -> IDLE when start=0 then RUN_WAIT on next start=1 (start must be released between rounds).
REQ-018 RUN_WAIT -> PULSE on tick_hit; PULSE lasts exactly one cycle with game_pulse=1, then WAIT_ACK.
REQ-019 WAIT_ACK -> UPDATE on the first cycle game_tick_after_draw differs from its value sampled in PULSE; tick_hit during WAIT_ACK is dropped, never queued.
REQ-020 UPDATE lasts one cycle, applies REQ-021..REQ-025, then -> OVER if collision else RUN_WAIT.
REQ-021 Velocity: 4-bit signed, down positive; if flap latched, vel=-FLAP_V and latch cleared, else vel=min(vel+1,+7).
REQ-022 box_y_next=box_y+vel computed in 8-bit signed; result <=0 or >=119 is collision and box_y clamps to 1 or 118.
REQ-023 pipe_one_x decrements by 1; at 0 it wraps to 159 and pipe_one_y loads (lfsr mod 80)+10 from a free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, never zero).
REQ-024 Collision when pipe_one_x in 3..5 and (box_y-1 < pipe_one_y or box_y+1 >= pipe_one_y+GAP_H), evaluated on updated values.
REQ-025 score increments when pipe_one_x goes 3 -> 2; saturates at 255.
REQ-026 Flap rising edge in any running state sets the latch; edge coincident with UPDATE is applied at the following UPDATE; held key counts once.
REQ-027 In IDLE/OVER, flap ignored, positions frozen, game_pulse=0.
REQ-028 Entering RUN_WAIT from IDLE reloads box_y=60, vel=0, pipe_one_x=159, pipe_one_y=40, score=0.

Reset
REQ-029 resetn=0 asynchronously forces: state IDLE, game_pulse 0, game_over 0, box_y 60, pipe_one_x 159, pipe_one_y 40, score 0, vel 0, flap latch 0, tick counter 0, LFSR 8'h5A.
REQ-030 Reset mid-handshake abandons the pending ack; ack-sample register reloads from game_tick_after_draw on first clock after release.

Structure
REQ-031 Package game_pkg holds screen width/height (160/120), bird column 4, state encoding, and reset positions.
REQ-032 Tick divider is a sub-module game_tick_divider (parameter TICK_DIV, output tick_hit).

Verification
REQ-033 TICK_DIV=10, start=1, painter toggles ack 3 cycles after each pulse -> game_pulse every 10 cycles, pipe_one_x 159,158,157.
REQ-034 No flap from box_y=60 -> box_y 61,63,66,70 over four updates, vel caps at 7.
REQ-035 Flap pulse, then hold key 50 cycles -> exactly one vel=-4 applied; box_y drops by 4.
REQ-036 Ack withheld for 3 tick periods -> single pulse, no update, no extra pulse until ack toggles.
REQ-037 pipe_one_x=4, pipe_one_y=40, box_y=30 at update -> game_over=1, score unchanged; pipe_one_x=0 -> wraps to 159 with new pipe_one_y in 10..89.
REQ-038 resetn low during WAIT_ACK -> all outputs at REQ-029 values same cycle, IDLE after release.
